// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Data-memory access stage placed directly after the ALU. A LOAD or STOR
//   starts a req/ack transaction on the data-memory bus. The core is held
//   through `stall` for the whole transaction. Loads return the read word to
//   the register file through a one-cycle write-back pulse.
//
//   FSM: IDLE -> BUSY -> DONE -> IDLE for a legal access.
//        IDLE -> DONE -> IDLE for a misaligned or ambiguous access.
//
// Ports
//   clk, reset         core clock; asynchronous active-low reset
//   run                core not halted; qualifies the start of an access
//   load, store        decoded LOAD / STOR of the current instruction
//   alu_result         effective byte address
//   regD_data          store data
//   stall              holds the pc and pipeline (combinational)
//   wr_load_reg        one-cycle write-back strobe for load_data
//   load_data          read word
//   bus_err            one-cycle pulse when the access timed out
//   align_err          one-cycle pulse for an odd address or load&store
//   mem_req/we/addr/wdata/rdata/ack   data-memory bus
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic        store,
    input  logic [15:0] alu_result,
    input  logic [15:0] regD_data,
    output logic        stall,
    output logic        wr_load_reg,
    output logic [15:0] load_data,
    output logic        bus_err,
    output logic        align_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_is_load;
    logic          r_timeout;
    logic          r_align;

    logic w_start;
    logic w_bad;
    logic w_ack;
    logic w_expire;

    // A start is only possible from IDLE. The decoded load/store stays high
    // through DONE, and this gating keeps it from re-triggering there.
    assign w_start  = run & (load | store) & (r_state == IDLE);
    assign w_bad    = alu_result[0] | (load & store);
    assign w_ack    = (r_state == BUSY) & mem_ack;
    // An ack in the last allowed cycle wins over the timeout.
    assign w_expire = (r_state == BUSY) & ~mem_ack & (r_cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so that no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = w_bad ? DONE : BUSY;
            BUSY: if (w_ack || w_expire) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_is_load <= 1'b0;
            r_timeout <= 1'b0;
            r_align   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            load_data <= 16'h0000;
        end else begin
            if (w_start) begin
                r_align   <= w_bad;
                r_timeout <= 1'b0;
                r_cnt     <= '0;
                // The bus fields are only loaded for a legal access, so a
                // rejected access leaves the previous bus state untouched.
                if (!w_bad) begin
                    mem_addr  <= alu_result;
                    mem_wdata <= regD_data;
                    mem_we    <= store;
                    r_is_load <= load;
                end
            end

            if (w_ack) begin
                load_data <= mem_rdata;
            end else if (w_expire) begin
                load_data <= 16'h0000;
                r_timeout <= 1'b1;
            end

            // Cleared on BUSY entry; it peaks at TIMEOUT_CYCLES, which fits CW.
            if (r_state == BUSY && !mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // mem_req is decoded from the state, so an asynchronous reset drops it
    // at once.
    assign mem_req     = (r_state == BUSY);
    assign stall       = w_start | (r_state == BUSY);
    assign wr_load_reg = (r_state == DONE) & r_is_load & ~r_timeout & ~r_align;
    assign bus_err     = (r_state == DONE) & r_timeout;
    assign align_err   = (r_state == DONE) & r_align;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. The stimulus pushes the expected
//   write-back, bus-error or align-error event into a scoreboard queue. A
//   monitor pops an entry and compares it whenever the DUT raises one of
//   those pulses. A bus responder acks after a programmable number of wait
//   cycles and records what the DUT put on the bus.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        load;
    logic        store;
    logic [15:0] alu_result;
    logic [15:0] regD_data;
    logic        stall;
    logic        wr_load_reg;
    logic [15:0] load_data;
    logic        bus_err;
    logic        align_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .load        (load),
        .store       (store),
        .alu_result  (alu_result),
        .regD_data   (regD_data),
        .stall       (stall),
        .wr_load_reg (wr_load_reg),
        .load_data   (load_data),
        .bus_err     (bus_err),
        .align_err   (align_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    typedef enum int {EV_WB = 0, EV_BUS = 1, EV_ALIGN = 2} ev_t;
    typedef struct {
        ev_t         kind;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Bus responder configuration and observations.
    int          bus_wait = -1;        // ack on this req cycle index; -1 = never
    logic [15:0] bus_rdata = 16'h0000;
    int          req_idx = 0;
    int          last_req_cycles = 0;
    int          txn_count = 0;
    bit          unstable = 1'b0;
    logic [15:0] cap_addr = 16'h0000;
    logic [15:0] cap_wdata = 16'h0000;
    logic        cap_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus responder: runs just after each rising edge.
    initial begin : responder
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (req_idx == 0) begin
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_we    = mem_we;
                    txn_count++;
                end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
                    unstable = 1'b1;
                end
                mem_ack   = (bus_wait >= 0) && (req_idx == bus_wait);
                mem_rdata = mem_ack ? bus_rdata : 16'hDEAD;
                req_idx++;
                last_req_cycles = req_idx;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'h0000;
                req_idx   = 0;
            end
        end
    end

    // Monitor: compares every result pulse against the scoreboard.
    initial begin : monitor
        ev_t  k;
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_load_reg || bus_err || align_err) begin
                k = wr_load_reg ? EV_WB : (bus_err ? EV_BUS : EV_ALIGN);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d, expected no event", k);
                end else begin
                    e = sb_q.pop_front();
                    check("event_kind", 32'(k), 32'(e.kind));
                    if (e.kind != EV_ALIGN) check("event_load_data", 32'(load_data), 32'(e.data));
                    check("event_one_hot", 32'(wr_load_reg) + 32'(bus_err) + 32'(align_err), 1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    // Issues one instruction, pushes its expected event, and counts the
    // stall cycles until the DONE cycle (stall low). It returns just after
    // the edge that ends DONE. With hold=1 the decoded load/store stays high.
    task automatic run_instr(input bit ld, input bit st, input logic [15:0] addr,
                             input logic [15:0] wdata, input int wait_n,
                             input logic [15:0] rdata, input int exp_stall,
                             input bit hold, input string name);
        exp_t e;
        int   n;
        bit   done;
        bus_wait  = wait_n;
        bus_rdata = rdata;
        if (addr[0] || (ld && st)) begin
            e.kind = EV_ALIGN; e.data = 16'h0000; sb_q.push_back(e);
        end else if (wait_n < 0 || wait_n >= T) begin
            e.kind = EV_BUS; e.data = 16'h0000; sb_q.push_back(e);
        end else if (ld) begin
            e.kind = EV_WB; e.data = rdata; sb_q.push_back(e);
        end
        run        = 1'b1;
        load       = ld;
        store      = st;
        alu_result = addr;
        regD_data  = wdata;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            n++;
            @(posedge clk);
        end
        check({name, "_reached_done"}, 32'(done), 1);
        check({name, "_stall_cycles"}, n, exp_stall);
        @(posedge clk);
        #1;
        if (!hold) begin
            load  = 1'b0;
            store = 1'b0;
        end
    endtask

    initial begin : stimulus
        int n0;
        reset = 1'b0; run = 1'b0; load = 1'b0; store = 1'b0;
        alu_result = 16'h0000; regD_data = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_load_data", 32'(load_data), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_pulses", 32'(wr_load_reg | bus_err | align_err), 0);
        reset = 1'b1;
        @(negedge clk);

        // LOAD 0x0010, immediate ack, read 0xBEEF.
        run_instr(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 2, 1'b0, "load_beef");
        check("load_beef_req_cycles", last_req_cycles, 1);
        check("load_beef_addr", 32'(cap_addr), 32'h0010);
        check("load_beef_we", 32'(cap_we), 0);

        // STOR 0x1234 to 0x0020, ack after 3 waits.
        unstable = 1'b0;
        run_instr(1'b0, 1'b1, 16'h0020, 16'h1234, 3, 16'hAAAA, 5, 1'b0, "store");
        check("store_req_cycles", last_req_cycles, 4);
        check("store_addr", 32'(cap_addr), 32'h0020);
        check("store_wdata", 32'(cap_wdata), 32'h1234);
        check("store_we", 32'(cap_we), 1);
        check("store_bus_stable", 32'(unstable), 0);

        // LOAD with no ack: times out after T request cycles.
        run_instr(1'b1, 1'b0, 16'h0030, 16'h0000, -1, 16'h0000, T + 1, 1'b0, "timeout");
        check("timeout_req_cycles", last_req_cycles, T);

        // LOAD with the ack in the last allowed cycle: the ack wins.
        run_instr(1'b1, 1'b0, 16'h0032, 16'h0000, T - 1, 16'h5A5A, T + 1, 1'b0, "late_ack");
        check("late_ack_req_cycles", last_req_cycles, T);

        // Odd address, then load&store together: no bus access.
        n0 = txn_count;
        run_instr(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 16'h0000, 1, 1'b0, "align_odd");
        run_instr(1'b1, 1'b1, 16'h0040, 16'h0000, 0, 16'h0000, 1, 1'b0, "align_ldst");
        check("align_no_bus", txn_count, n0);

        // Back-to-back loads with the decoded load held high across DONE.
        n0 = txn_count;
        run_instr(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'h1111, 2, 1'b1, "b2b_first");
        run_instr(1'b1, 1'b0, 16'h0052, 16'h0000, 0, 16'h2222, 2, 1'b0, "b2b_second");
        check("b2b_txn_count", txn_count, n0 + 2);
        check("b2b_second_addr", 32'(cap_addr), 32'h0052);

        // run=0 blocks the start of an access.
        @(negedge clk);
        n0 = txn_count;
        run = 1'b0; load = 1'b1; alu_result = 16'h0060;
        repeat (3) begin
            @(negedge clk);
            check("run0_stall", 32'(stall), 0);
        end
        check("run0_no_bus", txn_count, n0);
        load = 1'b0; run = 1'b1;

        // Reset asserted in the middle of a BUSY access.
        @(negedge clk);
        n0 = txn_count;
        bus_wait = -1;
        load = 1'b1; alu_result = 16'h0070;
        repeat (3) @(posedge clk);
        #3;
        check("midrst_req_before", 32'(mem_req), 1);
        reset = 1'b0;
        #1;
        check("midrst_req_dropped", 32'(mem_req), 0);
        load = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_idle_after", 32'(mem_req), 0);
        check("midrst_txn_count", txn_count, n0 + 1);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
